// File: rtl/apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
// Shared definitions for the multi-slave AHB-Lite to APB bridge:
//   - state_t     : bridge FSM states
//   - TR_*        : AHB HTRANS encodings
//   - calc_sel_w  : width of the slave-index field in HADDR
//   - calc_cnt_w  : width of the ACCESS wait counter
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLATCH,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  // max(1, $clog2(num_slv)): a single slave still needs a 1-bit field.
  function automatic int calc_sel_w(input int num_slv);
    return (num_slv <= 2) ? 1 : $clog2(num_slv);
  endfunction

  // max(1, $clog2(timeout+1)): counter must be able to hold the value timeout.
  function automatic int calc_cnt_w(input int timeout);
    return (timeout <= 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Saturating up-counter that measures APB ACCESS wait states.
// Ports:
//   clk, n_rst : clock, async active-low reset
//   clr        : synchronous clear (takes priority over inc)
//   inc        : count one wait cycle
//   expired    : high when the count is at MAX, or will reach MAX with this
//                cycle's increment, so the owner can leave on that same edge
// -----------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == MAX_V) || (inc && (cnt == MAX_V - 1'b1));

endmodule

// File: rtl/apb_bridge_mslv.sv
// -----------------------------------------------------------------------------
// apb_bridge_mslv
// AHB-Lite slave to multi-slave APB3 master bridge. One AHB region
// (HADDR[ADDR_W-1] == 1) is split into NUM_SLV APB slaves selected by
// HADDR[SEL_LSB +: SEL_W]. Slave errors, PREADY timeouts and unmapped indices
// are returned as the two-cycle AHB ERROR response.
//
// Ports:
//   clk, n_rst                 : clock, async active-low reset
//   HTRANS, HWRITE, HADDR      : AHB address phase
//   HWDATA                     : AHB write data (data phase)
//   HREADY, HRESP, HRDATA      : AHB response
//   PADDR, PWDATA, PWRITE      : APB shared request bus
//   PENABLE, PSEL[NUM_SLV]     : APB phase control, one-hot select
//   PRDATA, PREADY, PSLVERR    : per-slave APB responses (slave i at slice i)
//
// Handshake: HREADY is both "current transfer done" and "address phase
// accepted". A request (NONSEQ/SEQ inside the bridge region) is taken only
// on a clock edge where HREADY is high; HREADY is high in S_IDLE, in S_ERR2
// and in the S_ACCESS cycle where the selected slave completes with OKAY.
// On the APB side the access ends on the edge where PSEL[idx], PENABLE and
// PREADY[idx] are all high.
// -----------------------------------------------------------------------------
module apb_bridge_mslv
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 6,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 0
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [DATA_W-1:0]         HWDATA,
  output logic                      HREADY,
  output logic                      HRESP,
  output logic [DATA_W-1:0]         HRDATA,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W = calc_sel_w(NUM_SLV);

  state_t              state;
  state_t              state_nx;
  logic [SEL_W-1:0]    idx_q;
  logic [ADDR_W-1:0]   haddr_q;
  logic [SEL_W-1:0]    haddr_idx;
  logic                req;
  logic                addr_mapped;
  logic                hready_i;
  logic                take;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                timed_out;

  // Address-phase decode, independent of HREADY to keep the FSM loop-free.
  assign haddr_idx   = HADDR[SEL_LSB +: SEL_W];
  assign req         = ((HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ)) && HADDR[ADDR_W-1];
  assign addr_mapped = (32'(haddr_idx) < 32'(NUM_SLV));
  assign take        = hready_i && req;

  // Response mux for the slave owning the current access.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and HREADY. Every state with HREADY high samples a new
  // address phase with the same decode.
  always_comb begin
    state_nx = state;
    hready_i = 1'b0;
    case (state)
      S_IDLE:   hready_i = 1'b1;
      S_WLATCH: state_nx = S_SETUP;
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready && !sel_err) begin
          hready_i = 1'b1;
        end else if (sel_ready || timed_out) begin
          state_nx = S_ERR1;
        end
      end
      S_ERR1:   state_nx = S_ERR2;
      S_ERR2:   hready_i = 1'b1;
      default:  state_nx = S_IDLE;
    endcase
    if (hready_i) begin
      if (!req) begin
        state_nx = S_IDLE;
      end else if (!addr_mapped) begin
        state_nx = S_ERR1;
      end else if (HWRITE) begin
        state_nx = S_WLATCH;
      end else begin
        state_nx = S_SETUP;
      end
    end
  end

  // PADDR/PWRITE load only when a mapped access heads into SETUP, so they
  // hold across unmapped requests and idle periods.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      idx_q   <= '0;
      haddr_q <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        idx_q   <= haddr_idx;
        haddr_q <= HADDR;
      end
      if (take && addr_mapped && !HWRITE) begin
        PADDR  <= HADDR;
        PWRITE <= 1'b0;
      end else if (state == S_WLATCH) begin
        PADDR  <= haddr_q;
        PWRITE <= 1'b1;
        PWDATA <= HWDATA;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timer
      logic tmr_clr;
      logic tmr_inc;
      assign tmr_clr = (state == S_SETUP);
      assign tmr_inc = (state == S_ACCESS) && !sel_ready;
      apb_wait_timer #(
        .MAX (TIMEOUT),
        .W   (calc_cnt_w(TIMEOUT))
      ) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (timed_out)
      );
    end else begin : g_no_timer
      assign timed_out = 1'b0;
    end
  endgenerate

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      PSEL[i] = ((state == S_SETUP) || (state == S_ACCESS)) && (idx_q == SEL_W'(i));
    end
  end

  assign HREADY  = hready_i;
  assign HRESP   = (state == S_ERR1) || (state == S_ERR2);
  assign PENABLE = (state == S_ACCESS);
  // Read data is forwarded only on an OKAY read completion.
  assign HRDATA  = ((state == S_ACCESS) && !PWRITE && sel_ready && !sel_err) ? sel_rdata : '0;

endmodule

// File: tb/tb_apb_bridge_mslv.sv
// -----------------------------------------------------------------------------
// tb_apb_bridge_mslv
// Directed bench for apb_bridge_mslv (NUM_SLV=6, TIMEOUT=4). Transfers are
// described at transaction level; a planner expands them into per-cycle input
// vectors and expected outputs using the bridge's timing rules, then a driver
// and a compare process replay the plan against the DUT.
// -----------------------------------------------------------------------------
module tb_apb_bridge_mslv;
  import apb_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 6;
  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [AW-1:0]    HADDR;
  logic [DW-1:0]    HWDATA;
  logic             HREADY;
  logic             HRESP;
  logic [DW-1:0]    HRDATA;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic             PWRITE;
  logic             PENABLE;
  logic [NS-1:0]    PSEL;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]    PREADY;
  logic [NS-1:0]    PSLVERR;

  apb_bridge_mslv #(
    .ADDR_W (AW), .DATA_W (DW), .NUM_SLV (NS), .SEL_LSB (12), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .n_rst (n_rst),
    .HTRANS (HTRANS), .HWRITE (HWRITE), .HADDR (HADDR), .HWDATA (HWDATA),
    .HREADY (HREADY), .HRESP (HRESP), .HRDATA (HRDATA),
    .PADDR (PADDR), .PWDATA (PWDATA), .PWRITE (PWRITE), .PENABLE (PENABLE),
    .PSEL (PSEL), .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR)
  );

  typedef struct {
    logic          rst_n;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [31:0]   haddr;
    logic [31:0]   hwdata;
    logic [NS-1:0] pready;
    logic [NS-1:0] pslverr;
    logic          hready;
    logic          hresp;
    logic [31:0]   hrdata;
    logic [NS-1:0] psel;
    logic          penable;
    logic [31:0]   paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
  } cyc_t;

  cyc_t        cyc_q[$];
  cyc_t        cur;
  cyc_t        chk;
  int          chk_idx;
  logic [31:0] slot_data [NS];
  logic [31:0] m_paddr;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  int          n_vec = 0;
  int          n_mis = 0;

  // ---------------------------------------------------------------- model
  function automatic cyc_t blank();
    cyc_t c;
    c.rst_n   = 1'b1;
    c.htrans  = 2'($urandom_range(0, 1));
    c.hwrite  = 1'($urandom_range(0, 1));
    c.haddr   = $urandom;
    c.hwdata  = $urandom;
    c.pready  = NS'($urandom);
    c.pslverr = NS'($urandom);
    c.hready  = 1'b1;
    c.hresp   = 1'b0;
    c.hrdata  = '0;
    c.psel    = '0;
    c.penable = 1'b0;
    c.paddr   = m_paddr;
    c.pwrite  = m_pwrite;
    c.pwdata  = m_pwdata;
    return c;
  endfunction

  task automatic next_cyc();
    cyc_q.push_back(cur);
    cur = blank();
  endtask

  task automatic set_exp(input logic h, input logic r, input logic [31:0] rd,
                         input logic [NS-1:0] ps, input logic pe);
    cur.hready  = h;
    cur.hresp   = r;
    cur.hrdata  = rd;
    cur.psel    = ps;
    cur.penable = pe;
    cur.paddr   = m_paddr;
    cur.pwrite  = m_pwrite;
    cur.pwdata  = m_pwdata;
  endtask

  // Selected slave gets (rdy, err); every other slave gets the opposite so a
  // wrongly indexed response is visible.
  task automatic drive_slave(input int s, input logic rdy, input logic err);
    logic [NS-1:0] oh;
    oh = NS'(1 << s);
    cur.pready  = rdy ? oh : ~oh;
    cur.pslverr = err ? oh : ~oh;
  endtask

  // Address phase goes into the current cycle (one where HREADY is expected
  // high). On return, cur is the completing cycle (HREADY high) so the next
  // address may be placed back-to-back.
  task automatic plan_xfer(input logic [1:0] htr, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input int waits, input bit err,
                           input bit tmo, input bit abort);
    int s;
    logic [NS-1:0] oh;
    cur.htrans = htr;
    cur.hwrite = w;
    cur.haddr  = a;
    s = int'((a >> 12) % 8);
    if (s >= NS) begin
      next_cyc(); set_exp(1'b0, 1'b1, '0, '0, 1'b0);
      next_cyc(); set_exp(1'b1, 1'b1, '0, '0, 1'b0);
      return;
    end
    oh = NS'(1 << s);
    if (w) begin
      next_cyc(); cur.hwdata = wd; set_exp(1'b0, 1'b0, '0, '0, 1'b0);
    end
    next_cyc();
    m_paddr  = a;
    m_pwrite = w;
    if (w) m_pwdata = wd;
    set_exp(1'b0, 1'b0, '0, oh, 1'b0);
    if (abort) begin
      next_cyc(); drive_slave(s, 1'b0, 1'b0); set_exp(1'b0, 1'b0, '0, oh, 1'b1);
      m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
      next_cyc(); cur.rst_n = 1'b0; set_exp(1'b1, 1'b0, '0, '0, 1'b0);
      next_cyc();
      return;
    end
    for (int i = 0; i < (tmo ? TO : waits); i++) begin
      next_cyc(); drive_slave(s, 1'b0, 1'b0); set_exp(1'b0, 1'b0, '0, oh, 1'b1);
    end
    if (tmo || err) begin
      if (!tmo) begin
        next_cyc(); drive_slave(s, 1'b1, 1'b1); set_exp(1'b0, 1'b0, '0, oh, 1'b1);
      end
      next_cyc(); set_exp(1'b0, 1'b1, '0, '0, 1'b0);
      next_cyc(); set_exp(1'b1, 1'b1, '0, '0, 1'b0);
      return;
    end
    next_cyc(); drive_slave(s, 1'b1, 1'b0);
    set_exp(1'b1, 1'b0, w ? 32'h0 : slot_data[s], oh, 1'b1);
  endtask

  // ----------------------------------------------------------- scoreboard
  task automatic check_lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL model_%s: got %h required %h", nm, got, exp);
    end
  endtask

  function automatic bit diff(input string nm, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      $display("FAIL %s cycle %0d: got %h required %h", nm, chk_idx, got, exp);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic compare();
    bit bad;
    bad = 1'b0;
    bad |= diff("HREADY",  32'(HREADY),  32'(chk.hready));
    bad |= diff("HRESP",   32'(HRESP),   32'(chk.hresp));
    bad |= diff("HRDATA",  HRDATA,       chk.hrdata);
    bad |= diff("PSEL",    32'(PSEL),    32'(chk.psel));
    bad |= diff("PENABLE", 32'(PENABLE), 32'(chk.penable));
    bad |= diff("PADDR",   PADDR,        chk.paddr);
    bad |= diff("PWRITE",  32'(PWRITE),  32'(chk.pwrite));
    bad |= diff("PWDATA",  PWDATA,       chk.pwdata);
    n_vec++;
    if (bad) n_mis++;
  endtask

  task automatic apply(input cyc_t c);
    n_rst   = c.rst_n;
    HTRANS  = c.htrans;
    HWRITE  = c.hwrite;
    HADDR   = c.haddr;
    HWDATA  = c.hwdata;
    PREADY  = c.pready;
    PSLVERR = c.pslverr;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int n;
    n_rst = 1'b0; HTRANS = TR_IDLE; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
    PREADY = '0; PSLVERR = '0;
    slot_data[0] = 32'h0A0A_0000; slot_data[1] = 32'h1111_1111;
    slot_data[2] = 32'hDEAD_BEEF; slot_data[3] = 32'h3C3C_3C3C;
    slot_data[4] = 32'h4444_4444; slot_data[5] = 32'h5A5A_5A5A;
    for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = slot_data[i];
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;

    // reset held two cycles, then idle
    cur = blank(); cur.rst_n = 1'b0;
    next_cyc(); cur.rst_n = 1'b0;
    next_cyc();
    next_cyc();

    // read slave 2, zero wait
    plan_xfer(TR_NONSEQ, 1'b0, 32'h8000_2010, '0, 0, 0, 0, 0);
    check_lit("rd2_setup_psel", 32'(cyc_q[cyc_q.size()-1].psel), 32'h0000_0004);
    check_lit("rd2_access_psel", 32'(cur.psel), 32'h0000_0004);
    check_lit("rd2_hrdata", cur.hrdata, 32'hDEAD_BEEF);
    next_cyc();

    // write slave 0, three wait states
    plan_xfer(TR_NONSEQ, 1'b1, 32'h8000_0040, 32'h1234_5678, 3, 0, 0, 0);
    n = cyc_q.size();
    check_lit("wr0_hready_seq", {26'd0, cyc_q[n-5].hready, cyc_q[n-4].hready, cyc_q[n-3].hready,
                                 cyc_q[n-2].hready, cyc_q[n-1].hready, cur.hready}, 32'h0000_0001);
    check_lit("wr0_setup_pwdata", cyc_q[n-4].pwdata, 32'h1234_5678);
    check_lit("wr0_access_pwdata", cur.pwdata, 32'h1234_5678);
    next_cyc();

    // unmapped index 7, then back-to-back read of slave 4 ending in PSLVERR
    plan_xfer(TR_NONSEQ, 1'b0, 32'h8000_7000, '0, 0, 0, 0, 0);
    n = cyc_q.size();
    check_lit("unm_err1", {29'd0, cyc_q[n-1].hresp, cyc_q[n-1].hready, 1'b0}, 32'h0000_0004);
    check_lit("unm_err2", {30'd0, cur.hresp, cur.hready}, 32'h0000_0003);
    check_lit("unm_psel", 32'(cyc_q[n-1].psel), 32'h0);
    plan_xfer(TR_NONSEQ, 1'b0, 32'h8000_4010, '0, 1, 1, 0, 0);
    n = cyc_q.size();
    check_lit("slverr_psel", 32'(cyc_q[n-2].psel), 32'h0000_0010);
    check_lit("slverr_hready", 32'(cyc_q[n-2].hready), 32'h0);
    check_lit("slverr_hrdata", cyc_q[n-2].hrdata, 32'h0);
    next_cyc();

    // requests that must be ignored: outside the region, and BUSY
    cur.htrans = TR_NONSEQ; cur.hwrite = 1'b0; cur.haddr = 32'h0000_3000;
    next_cyc();
    cur.htrans = TR_BUSY; cur.hwrite = 1'b1; cur.haddr = 32'h8000_3000;
    next_cyc();

    // slave 5 never ready: timeout after 4 wait cycles
    plan_xfer(TR_NONSEQ, 1'b0, 32'h8000_5008, '0, 0, 0, 1, 0);
    n = cyc_q.size();
    check_lit("tmo_last_access_psel", 32'(cyc_q[n-2].psel), 32'h0000_0020);
    check_lit("tmo_first_access_pen", 32'(cyc_q[n-5].penable), 32'h1);
    check_lit("tmo_err1_psel", 32'(cyc_q[n-1].psel), 32'h0);
    next_cyc();

    // back-to-back read, read, write; reset during the write's ACCESS
    plan_xfer(TR_NONSEQ, 1'b0, 32'h8000_1004, '0, 0, 0, 0, 0);
    plan_xfer(TR_SEQ, 1'b0, 32'h8000_3FFC, '0, 2, 0, 0, 0);
    plan_xfer(TR_SEQ, 1'b1, 32'h8000_5ABC, 32'hA5A5_0F0F, 0, 0, 0, 1);
    n = cyc_q.size();
    check_lit("rst_psel", 32'(cyc_q[n-1].psel), 32'h0);
    check_lit("rst_hready", 32'(cyc_q[n-1].hready), 32'h1);
    check_lit("rst_pwdata", cyc_q[n-1].pwdata, 32'h0);

    // normal traffic after reset, then unmapped boundary index 6
    plan_xfer(TR_NONSEQ, 1'b0, 32'h8000_2020, '0, 1, 0, 0, 0);
    plan_xfer(TR_SEQ, 1'b1, 32'h8000_1100, 32'hCAFE_F00D, 0, 0, 0, 0);
    next_cyc();
    plan_xfer(TR_NONSEQ, 1'b1, 32'h8000_6000, 32'h0BAD_0BAD, 0, 0, 0, 0);
    next_cyc();
    next_cyc();
    cyc_q.push_back(cur);

    fork
      begin
        foreach (cyc_q[i]) begin
          @(posedge clk);
          #1;
          apply(cyc_q[i]);
          chk     = cyc_q[i];
          chk_idx = i;
        end
      end
      begin
        for (int k = 0; k < cyc_q.size(); k++) begin
          @(negedge clk);
          compare();
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
